mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
Shares one single-port unified instruction/data memory between the IF stage (fetch) and the MEM stage (lw/sw).
- Registered FSM: issues one memory transaction at a time, holds address/data stable until the memory acks, then returns the result with a one-cycle valid pulse.
- Produces the stall signals the hazard logic ORs into pcwrite/if_id_write.
- Data requests have priority over fetch.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 255, max wait cycles for m_ack (used only with optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
if_req  in  1  fetch request, held until if_valid
if_addr  in  AW  fetch address (PC)
if_rdata  out  DW  fetched instruction, valid with if_valid
if_valid  out  1  one-cycle fetch-done pulse
d_rd  in  1  load request (EX/MEM MemRead), held until d_valid
d_wr  in  1  store request (EX/MEM MemWrite), held until d_valid
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_rdata  out  DW  load data, valid with d_valid
d_valid  out  1  one-cycle data-done pulse (loads and stores)
stall_if  out  1  freeze PC and IF/ID
stall_pipe  out  1  freeze whole pipeline (data access pending)
mem_err  out  1  timeout pulse alongside valid; constant 0 without feature
m_req  out  1  memory request, registered
m_we  out  1  memory write enable, registered
m_addr  out  AW  memory address, registered
m_wdata  out  DW  memory write data, registered
m_rdata  in  DW  memory read data, sampled when m_ack=1
m_ack  in  1  memory completion, single-cycle, allowed in first m_req cycle

Behaviour:
- Reset values: state IDLE. m_req, m_we, if_valid, d_valid, mem_err = 0. m_addr, m_wdata, if_rdata, d_rdata = 0.
- States:
  - IDLE: if (d_rd|d_wr) and !d_valid, latch d_addr/d_wdata, m_we=d_wr, m_req=1, go D_WAIT. Else if if_req and !if_valid, latch if_addr, m_we=0, m_req=1, go I_WAIT. Else stay.
  - D_WAIT: m_req/m_addr/m_we/m_wdata held. On m_ack: m_req=0; d_rdata<=m_rdata for loads, unchanged for stores; d_valid=1 next cycle; go IDLE.
  - I_WAIT: same as D_WAIT, but on m_ack: if_rdata<=m_rdata, if_valid=1 next cycle.
- Valid-cycle guard: in the cycle d_valid (if_valid) is 1, the same requester's request is treated as consumed and is not re-arbitrated. The other requester may be granted in that cycle.
- d_rd and d_wr both high: treated as a store (m_we=1).
- Priority: data beats fetch whenever both are pending in IDLE. Fetch cannot starve indefinitely because a stalled pipeline issues no new data requests.
- Latency: request at cycle 0 -> m_req at cycle 1. With m_ack at cycle k≥1, valid at cycle k+1. Minimum 2 cycles.
- stall_pipe = (d_rd|d_wr) & !d_valid (combinational).
- stall_if = stall_pipe | (if_req & !if_valid).
- m_ack while IDLE is ignored.
- Requester dropping its request mid-transaction: transaction still completes and the valid pulse still fires.
- Reset mid-transaction: immediate return to IDLE with m_req=0. A late m_ack after reset is ignored.
- rdata registers hold their value until the next completion of the same requester.

Optional Feature:
MEM_ARB_TIMEOUT_EN:
- Defined:
  - An 8+ bit wait counter clears on entry to D_WAIT/I_WAIT and increments each cycle without m_ack.
  - When the counter reaches TIMEOUT: drop m_req, pulse the owner's valid with mem_err=1, leave rdata unchanged, go IDLE.
  - m_ack on the same cycle as timeout wins (normal completion).
- Undefined: no counter; mem_err tied 0; waits forever.

Decomposition:
- Package mips_mem_pkg: arb_state_t enum {IDLE, D_WAIT, I_WAIT}, AW/DW default localparams, owner_t enum {OWN_I, OWN_D}.
- Sub-module mem_arb_watchdog (counter plus timeout compare) instantiated only under MEM_ARB_TIMEOUT_EN.

Test Plan:
- Reset, then if_req=1, if_addr=0x0 with memory acking on the first m_req cycle -> m_req at cycle 1, if_valid at cycle 2, if_rdata=m_rdata; stall_if is 1 for cycles 0-1 and 0 at cycle 2.
- if_req and d_rd asserted together, d_addr=0x40 -> data granted first (m_addr=0x40, m_we=0). Fetch is issued in the cycle d_valid pulses. stall_pipe holds until d_valid.
- d_wr=1, d_addr=0x10, d_wdata=0xDEADBEEF, ack after 3 wait cycles -> m_we=1, m_wdata=0xDEADBEEF stable for 4 cycles, d_valid a single pulse, d_rdata unchanged.
- Back-to-back lw then sw (request held high through the valid cycle) -> exactly two m_req transactions, no duplicate issue.
- rst asserted in D_WAIT, m_ack arrives 1 cycle after rst release -> m_req=0 immediately, ack ignored, no valid pulse.
- (MEM_ARB_TIMEOUT_EN, TIMEOUT=4) m_ack never asserted -> after 4 wait cycles m_req drops, d_valid=1 and mem_err=1 for one cycle, state IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and defaults for the unified memory port arbiter
// Package mips_mem_pkg
//   arb_state_t : arbiter FSM states (IDLE, D_WAIT, I_WAIT)
//   owner_t     : which requester owns the outstanding transaction
//   AW_DEF/DW_DEF : default address/data widths
package mips_mem_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_WAIT = 2'd1,
        I_WAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // The wait state itself records who owns the memory.
    function automatic owner_t state_owner(input arb_state_t s);
        return (s == D_WAIT) ? OWN_D : OWN_I;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data request and memory bus bundle for the arbiter
// Signals
//   fetch side : if_req, if_addr -> if_rdata, if_valid
//   data side  : d_rd, d_wr, d_addr, d_wdata -> d_rdata, d_valid
//   hazard     : stall_if, stall_pipe, mem_err
//   memory     : m_req, m_we, m_addr, m_wdata -> m_rdata, m_ack
// Modports
//   slave  : the arbiter's view
//   master : the pipeline + memory environment's view
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;

    logic          d_rd;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_valid;

    logic          stall_if;
    logic          stall_pipe;
    logic          mem_err;

    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ack;

    modport slave (
        input  if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, m_rdata, m_ack,
        output if_rdata, if_valid, d_rdata, d_valid, stall_if, stall_pipe,
               mem_err, m_req, m_we, m_addr, m_wdata
    );

    modport master (
        output if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, m_rdata, m_ack,
        input  if_rdata, if_valid, d_rdata, d_valid, stall_if, stall_pipe,
               mem_err, m_req, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_arb_watchdog.sv
// rtl/mem_arb_watchdog.sv - wait-cycle counter that flags a memory transaction that never acks
// Used only when MEM_ARB_TIMEOUT_EN is defined.
// Ports
//   clk, rst : clock, asynchronous active-high reset
//   active   : a transaction is outstanding (counter clears while low)
//   ack      : memory completion this cycle
//   timeout  : this cycle is the TIMEOUT-th wait cycle without ack
module mem_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ack,
    output logic timeout
);
    localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!active) begin
            cnt_d = '0;
        end else if (!ack) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Fires in the cycle the count would reach TIMEOUT; an ack in the same
    // cycle takes precedence so the transaction completes normally.
    assign timeout = active && !ack && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between instruction fetch and load/store
// One transaction at a time; data requests win over fetch. Address/data are
// registered and held until m_ack, then the owner gets a one-cycle valid pulse.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to abort a wait after TIMEOUT
// cycles with mem_err; otherwise mem_err is 0 and waits are unbounded.
// Ports
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mem_port_arbiter_if.slave (fetch, data, stall, memory signals)
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = 255
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);
    arb_state_t    state_q,    state_d;
    logic          m_req_q,    m_req_d;
    logic          m_we_q,     m_we_d;
    logic [AW-1:0] m_addr_q,   m_addr_d;
    logic [DW-1:0] m_wdata_q,  m_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q,  d_rdata_d;
    logic          if_valid_q, if_valid_d;
    logic          d_valid_q,  d_valid_d;
    logic          mem_err_q,  mem_err_d;

    logic   d_req;
    logic   timeout_hit;
    owner_t owner;

    assign d_req = bus.d_rd | bus.d_wr;
    assign owner = state_owner(state_q);

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .active  (state_q != IDLE),
        .ack     (bus.m_ack),
        .timeout (timeout_hit)
    );
`else
    // No watchdog: an outstanding wait never expires.
    assign timeout_hit = (TIMEOUT < 0);
`endif

    always_comb begin
        state_d    = state_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_valid_d = 1'b0;
        d_valid_d  = 1'b0;
        mem_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // A requester whose valid is pulsing this cycle is done; its
                // still-high request must not start a second transaction.
                if (d_req && !d_valid_q) begin
                    m_req_d   = 1'b1;
                    m_we_d    = bus.d_wr;
                    m_addr_d  = bus.d_addr;
                    m_wdata_d = bus.d_wdata;
                    state_d   = D_WAIT;
                end else if (bus.if_req && !if_valid_q) begin
                    m_req_d  = 1'b1;
                    m_we_d   = 1'b0;
                    m_addr_d = bus.if_addr;
                    state_d  = I_WAIT;
                end
            end
            D_WAIT, I_WAIT: begin
                if (bus.m_ack) begin
                    m_req_d = 1'b0;
                    m_we_d  = 1'b0;
                    state_d = IDLE;
                    if (owner == OWN_D) begin
                        d_valid_d = 1'b1;
                        if (!m_we_q) begin
                            d_rdata_d = bus.m_rdata;
                        end
                    end else begin
                        if_valid_d = 1'b1;
                        if_rdata_d = bus.m_rdata;
                    end
                end else if (timeout_hit) begin
                    m_req_d   = 1'b0;
                    m_we_d    = 1'b0;
                    state_d   = IDLE;
                    mem_err_d = 1'b1;
                    if (owner == OWN_D) begin
                        d_valid_d = 1'b1;
                    end else begin
                        if_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                m_req_d = 1'b0;
                m_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_valid_q <= if_valid_d;
            d_valid_q  <= d_valid_d;
            mem_err_q  <= mem_err_d;
        end
    end

    // Stalls are combinational so the hazard unit freezes the pipe in the
    // same cycle a request appears, and releases it in the valid cycle.
    assign bus.stall_pipe = d_req & ~d_valid_q;
    assign bus.stall_if   = bus.stall_pipe | (bus.if_req & ~if_valid_q);

    assign bus.m_req    = m_req_q;
    assign bus.m_we     = m_we_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_wdata  = m_wdata_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.if_valid = if_valid_q;
    assign bus.d_valid  = d_valid_q;
    assign bus.mem_err  = mem_err_q;
endmodule
